rpi_reg_xfer: RTL and testbench

RPI_REG_XFER -- requirements
Module: rpi_reg_xfer

---
 rtl/rpi_reg_xfer.sv | 152 +++++++++++++++
 tb/tb_rpi_reg_xfer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rpi_reg_xfer.sv
// Pi register transfer: the Pi moves one byte per 4-phase frame as two nibbles.
// Optional RPI_XFER_PARITY_EN adds a phase-3 check nibble (hi ^ lo) on reads and writes.
module rpi_reg_xfer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic [3:0] reg_sel,
  input  logic [7:0] ti_td,
  input  logic [7:0] ti_tc,
  output logic [3:0] dout,
  output logic [7:0] rd,
  output logic [7:0] rc,
  output logic       rd_stb,
  output logic       rc_stb,
  output logic       td_ack,
  output logic       perr,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  phase_e     phase_q, phase_d;
  logic [3:0] dout_q, dout_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] snap_q, snap_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] rc_q, rc_d;
  logic       rd_stb_q, rd_stb_d;
  logic       rc_stb_q, rc_stb_d;
  logic       td_ack_q, td_ack_d;

  logic       isRead;
  logic       isWrite;
  logic [7:0] srcByte;
  logic       checkOk;
  logic [3:0] readCheck;

  assign isRead  = (reg_sel == 4'h0) || (reg_sel == 4'h1);
  assign isWrite = (reg_sel == 4'h2) || (reg_sel == 4'h3);
  assign srcByte = reg_sel[0] ? ti_tc : ti_td;

`ifdef RPI_XFER_PARITY_EN
  logic perr_q, perr_d;

  assign checkOk   = (din == (hold_q[7:4] ^ hold_q[3:0]));
  assign readCheck = snap_q[7:4] ^ snap_q[3:0];
  assign perr      = perr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  always_comb begin
    perr_d = perr_q;
    if (phase_q == PH3 && isWrite) perr_d = !checkOk;
  end
`else
  assign checkOk   = 1'b1;
  assign readCheck = 4'h0;
  assign perr      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH0;
      dout_q   <= 4'h0;
      hold_q   <= 8'h00;
      snap_q   <= 8'h00;
      rd_q     <= 8'h00;
      rc_q     <= 8'h00;
      rd_stb_q <= 1'b0;
      rc_stb_q <= 1'b0;
      td_ack_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      dout_q   <= dout_d;
      hold_q   <= hold_d;
      snap_q   <= snap_d;
      rd_q     <= rd_d;
      rc_q     <= rc_d;
      rd_stb_q <= rd_stb_d;
      rc_stb_q <= rc_stb_d;
      td_ack_q <= td_ack_d;
    end
  end

  // Phase 0 belongs to the upstream select stage, so this block only idles there.
  always_comb begin
    phase_d  = PH0;
    dout_d   = dout_q;
    hold_d   = hold_q;
    snap_d   = snap_q;
    rd_d     = rd_q;
    rc_d     = rc_q;
    rd_stb_d = 1'b0;
    rc_stb_d = 1'b0;
    td_ack_d = 1'b0;
    unique case (phase_q)
      PH0: begin
        phase_d = PH1;
      end
      PH1: begin
        phase_d = PH2;
        dout_d  = 4'h0;
        if (isRead) begin
          snap_d = srcByte;
          dout_d = srcByte[7:4];
        end else if (isWrite) begin
          hold_d = {din, hold_q[3:0]};
        end
      end
      PH2: begin
        phase_d = PH3;
        dout_d  = 4'h0;
        if (isRead) dout_d = snap_q[3:0];
        else if (isWrite) hold_d = {hold_q[7:4], din};
      end
      PH3: begin
        phase_d = PH0;
        dout_d  = 4'h0;
        if (isRead) begin
          dout_d   = readCheck;
          td_ack_d = !reg_sel[0];
        end else if (isWrite && checkOk) begin
          if (reg_sel[0]) begin
            rc_d     = hold_q;
            rc_stb_d = 1'b1;
          end else begin
            rd_d     = hold_q;
            rd_stb_d = 1'b1;
          end
        end
      end
      default: phase_d = PH0;
    endcase
  end

  assign dout   = dout_q;
  assign rd     = rd_q;
  assign rc     = rc_q;
  assign rd_stb = rd_stb_q;
  assign rc_stb = rc_stb_q;
  assign td_ack = td_ack_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_rpi_reg_xfer.sv
// Scoreboard bench for rpi_reg_xfer: frames are issued by a stimulus process,
// expectations come from a byte-level register model, a monitor compares per frame.
module tb_rpi_reg_xfer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = 4'h0;
  logic [3:0] reg_sel = 4'hF;
  logic [7:0] ti_td = 8'h00;
  logic [7:0] ti_tc = 8'h00;
  logic [3:0] dout;
  logic [7:0] rd, rc;
  logic       rd_stb, rc_stb, td_ack, perr;
  logic [1:0] phase;

  rpi_reg_xfer dut (
    .clk(clk), .reset(reset), .din(din), .reg_sel(reg_sel),
    .ti_td(ti_td), .ti_tc(ti_tc), .dout(dout), .rd(rd), .rc(rc),
    .rd_stb(rd_stb), .rc_stb(rc_stb), .td_ack(td_ack), .perr(perr), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       checkDout;
    logic [3:0] n1, n2, n3;
    logic [7:0] rdV, rcV;
    logic       rdS, rcS, ack, pe;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

`ifdef RPI_XFER_PARITY_EN
  localparam bit ParityOn = 1'b1;
`else
  localparam bit ParityOn = 1'b0;
`endif

  logic [7:0] rdM = 8'h00;
  logic [7:0] rcM = 8'h00;
  logic       perrM = 1'b0;

  // Frame position as the bench sees it: counts clock edges since reset release.
  logic [1:0] mPhase;
  always @(posedge clk or negedge reset) begin
    if (!reset) mPhase <= 2'd0;
    else        mPhase <= mPhase + 2'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full frame; the source bytes switch to the "late" values right after the snapshot edge.
  task automatic applyStimulus(input logic [3:0] sel, input logic [3:0] hi, input logic [3:0] lo,
                               input logic [3:0] chk, input logic [7:0] td, input logic [7:0] tc,
                               input logic [7:0] tdLate, input logic [7:0] tcLate);
    exp_t       e;
    logic [7:0] b;
    logic       ok;
    do @(negedge clk); while (mPhase != 2'd1);
    reg_sel = sel; din = hi; ti_td = td; ti_tc = tc;
    e.checkDout = !(sel == 4'h2 || sel == 4'h3);
    e.n1 = 4'h0; e.n2 = 4'h0; e.n3 = 4'h0;
    e.rdS = 1'b0; e.rcS = 1'b0; e.ack = 1'b0;
    if (sel <= 4'h1) begin
      b    = (sel == 4'h0) ? td : tc;
      e.n1 = b[7:4];
      e.n2 = b[3:0];
      e.n3 = ParityOn ? (b[7:4] ^ b[3:0]) : 4'h0;
      e.ack = (sel == 4'h0);
    end else if (sel <= 4'h3) begin
      ok = !ParityOn || (chk == (hi ^ lo));
      if (ok) begin
        if (sel == 4'h2) begin rdM = {hi, lo}; e.rdS = 1'b1; end
        else             begin rcM = {hi, lo}; e.rcS = 1'b1; end
        perrM = 1'b0;
      end else begin
        perrM = 1'b1;
      end
    end
    e.rdV = rdM; e.rcV = rcM; e.pe = perrM;
    expQ.push_back(e);
    @(negedge clk);
    din = lo; ti_td = tdLate; ti_tc = tcLate;
    @(negedge clk);
    din = chk;
    @(negedge clk);
  endtask

  // Monitor: collects the two nibbles, then judges the frame at the edge that ends it.
  logic [3:0] capN1, capN2;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      checkOutput("phase", {30'd0, phase}, {30'd0, mPhase});
      if (mPhase == 2'd2) capN1 = dout;
      if (mPhase == 2'd3) capN2 = dout;
      if (mPhase == 2'd0 && expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.checkDout) begin
          checkOutput("dout_n1", {28'd0, capN1}, {28'd0, e.n1});
          checkOutput("dout_n2", {28'd0, capN2}, {28'd0, e.n2});
          checkOutput("dout_n3", {28'd0, dout}, {28'd0, e.n3});
        end
        checkOutput("rd", {24'd0, rd}, {24'd0, e.rdV});
        checkOutput("rc", {24'd0, rc}, {24'd0, e.rcV});
        checkOutput("rd_stb", {31'd0, rd_stb}, {31'd0, e.rdS});
        checkOutput("rc_stb", {31'd0, rc_stb}, {31'd0, e.rcS});
        checkOutput("td_ack", {31'd0, td_ack}, {31'd0, e.ack});
        checkOutput("perr", {31'd0, perr}, {31'd0, e.pe});
      end else begin
        checkOutput("idle_strobes", {29'd0, rd_stb, rc_stb, td_ack}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] sel, hi, lo, chk;
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_dout", {28'd0, dout}, 32'd0);
    checkOutput("reset_rd_rc", {16'd0, rd, rc}, 32'd0);
    checkOutput("reset_phase", {30'd0, phase}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed frames
    applyStimulus(4'h2, 4'hA, 4'h5, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 8'h3C, 8'h77, 8'hFF, 8'hFF);
    applyStimulus(4'h1, 4'h0, 4'h0, 4'h0, 8'h11, 8'hD2, 8'h00, 8'h00);
    applyStimulus(4'h9, 4'h6, 4'h6, 4'h6, 8'h5A, 8'hA5, 8'h5A, 8'hA5);
    applyStimulus(4'h2, 4'h1, 4'h1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(4'h3, 4'h2, 4'h2, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef RPI_XFER_PARITY_EN
    applyStimulus(4'h3, 4'h1, 4'h2, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(4'h3, 4'h1, 4'h2, 4'h3, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    // Reset in the middle of a write frame with only the high nibble captured
    do @(negedge clk); while (mPhase != 2'd1);
    reg_sel = 4'h2; din = 4'h7;
    @(negedge clk);
    din = 4'h3;
    reset = 1'b0;
    #1;
    checkOutput("midreset_outs", {19'd0, dout, rd_stb, rc_stb, td_ack, perr, phase},
                32'd0);
    checkOutput("midreset_regs", {16'd0, rd, rc}, 32'd0);
    rdM = 8'h00; rcM = 8'h00; perrM = 1'b0;
    @(negedge clk);
    reg_sel = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_phase", {30'd0, phase}, 32'd1);
    checkOutput("post_reset_rd", {24'd0, rd}, 32'd0);

    // Randomized frames
    for (int i = 0; i < 48; i++) begin
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      hi  = 4'($urandom_range(0, 15));
      lo  = 4'($urandom_range(0, 15));
      chk = ($urandom_range(0, 3) != 0) ? (hi ^ lo) : 4'($urandom_range(0, 15));
      applyStimulus(sel, hi, lo, chk, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    reg_sel = 4'hF;
    repeat (4) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
